serial_adder: RTL
=================

// Module: serial_adder
//
// PURPOSE
//   Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
//   A single carry flip-flop serialises the carry chain.
//   Trades latency (WIDTH+1 cycles) for a one-bit datapath. Sits behind any block needing cheap wide addition.
//   Uses a start/busy/done handshake; the result is held stable between operations.
//
// PARAMETERS
//   WIDTH   8   operand and sum width in bits; legal range WIDTH >= 1
//
// PORTS
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled on rising clk while not busy
//   a       in   WIDTH  operand A; sampled only on the accepting edge
//   b       in   WIDTH  operand B; sampled only on the accepting edge
//   cin     in   1      carry-in; sampled only on the accepting edge
//   busy    out  1      high while an addition is in progress
//   done    out  1      one-cycle pulse: sum/cout have just been updated
//   sum     out  WIDTH  result of the last completed addition
//   cout    out  1      carry-out of the last completed addition
//
// BEHAVIOUR
//   Reset (rst_n low, async)
//     - state=IDLE; busy=0, done=0, sum=0, cout=0.
//     - Shift registers, bit counter and carry FF are cleared.
//   States: IDLE, SHIFT, DONE.
//   IDLE
//     - start=1 on edge k: load a_sr<=a, b_sr<=b, c<=cin, cnt<=0; go to SHIFT.
//   SHIFT
//     - Each edge: s_bit = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0], b_sr[0], c).
//     - Shift a_sr and b_sr right; shift s_bit into the MSB of s_sr; cnt++.
//     - On the edge where cnt==WIDTH-1: sum<=final s_sr, cout<=final carry, done<=1, go to DONE.
//   DONE
//     - Lasts exactly one cycle, with done=1.
//     - Next edge: done<=0. With start=1 it loads new operands and goes to SHIFT (back-to-back); otherwise IDLE.
//   Handshake and latency
//     - busy=1 exactly while in SHIFT: WIDTH cycles.
//     - Start accepted on edge k gives done high in the cycle after edge k+WIDTH.
//   Boundary conditions
//     - start during SHIFT is ignored; operands in flight are unaffected.
//     - sum/cout change only on the completion edge and never show partial results.
//     - Sum wraps modulo 2^WIDTH; overflow appears only on cout.
//     - WIDTH=1: a single SHIFT cycle.
//     - rst_n asserted mid-operation aborts immediately: all outputs go to 0 and no done is issued.
//     - a/b/cin changing after acceptance has no effect.
//
// STRUCTURE
//   - Header serial_adder_defs.vh holds the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
//   - Counter width = $clog2(WIDTH+1), computed locally.
//   - Sub-module full_adder_bit: one-bit full adder built from two instances of the team's halfadder cell plus an OR.
//     It is combinational and instantiated once in the datapath.
//   - The FSM, shift registers, carry FF and result registers live in serial_adder.
//
// TESTING (WIDTH=8)
//   1. rst_n=0 with random inputs -> busy=0, done=0, sum=8'h00, cout=0; release, idle with no activity.
//   2. a=8'h35, b=8'h4A, cin=0, start 1 cycle -> busy for 8 cycles, done pulse 1 cycle, sum=8'h7F, cout=0.
//   3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//      Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//   4. start for a=8'h10, b=8'h20; at cycle 3 pulse start with a=8'hAA, b=8'h55
//      -> second request ignored; result sum=8'h30, cout=0; exactly one done.
//   5. start held high continuously with a=8'h01, b=8'h01
//      -> back-to-back ops; done every 9 cycles; sum=8'h02 each time.
//   6. rst_n low mid-SHIFT (cycle 4)
//      -> busy/done/sum/cout drop to 0 immediately; no done after release until a new start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types for the bit-serial adder (FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================================
// Module      : serial_adder_if
// Description : start/busy/done request interface of the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface : serial_adder_if

`default_nettype wire

// File: rtl/serial_adder_full_adder_bit.sv
// ============================================================================
// Module      : halfadder / full_adder_bit
// Description : Half-adder cell and a one-bit full adder built from two of them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halfadder (
    input  wire logic i_a,
    input  wire logic i_b,
    output logic      o_s,
    output logic      o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule : halfadder

module full_adder_bit (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_cin,
    output logic      o_s,
    output logic      o_cout
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    halfadder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1), .o_c(w_c1));
    halfadder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_s),  .o_c(w_c2));

    assign o_cout = w_c1 | w_c2;
endmodule : full_adder_bit

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    serial_adder_if.slave bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_s_sr;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_s_bit;
    logic               w_c_next;
    logic [WIDTH-1:0]   w_s_next;
    logic               w_unused;

    full_adder_bit u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_c),
        .o_s    (w_s_bit),
        .o_cout (w_c_next)
    );

    // Partial-sum register after shifting the new bit into the MSB.
    generate
        if (WIDTH == 1) begin : g_snext_w1
            assign w_s_next = w_s_bit;
        end else begin : g_snext_wn
            assign w_s_next = {w_s_bit, r_s_sr[WIDTH-1:1]};
        end
    endgenerate

    assign w_unused = r_s_sr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_c     <= bus.cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_c    <= w_c_next;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_s_sr <= w_s_next;
                    r_cnt  <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_c_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule : serial_adder

`default_nettype wire
